// File: rtl/alu_pkg.sv
// Shared constants for the ALU sequencer: opcodes, flag bit positions, FSM states.
package alu_pkg;
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_XOR  = 3'd2;
   localparam logic [2:0] OP_SLT  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_NAND = 3'd5;
   localparam logic [2:0] OP_NOR  = 3'd6;
   localparam logic [2:0] OP_OR   = 3'd7;

   localparam int FLAG_OVF  = 2;
   localparam int FLAG_ZERO = 1;
   localparam int FLAG_COUT = 0;
   localparam int NUM_FLAGS = 3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } seq_state_t;
endpackage

// File: rtl/alu_settle_counter.sv
// Loadable down-counter timing the ALU settle window; done while the count is zero.
module alu_settle_counter
   import alu_pkg::*;
#(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          load,
   input  logic [CW-1:0] load_value,
   input  logic          dec,
   output logic          done
);
   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (reset)                    count <= '0;
      else if (load)                count <= load_value;
      else if (dec && count != '0)  count <= count - 1'b1;
   end

   assign done = (count == '0);
endmodule

// File: rtl/alu_op_sequencer.sv
// Issues one op to the ALU, holds inputs for a settle window, returns captured result/flags.
// Optional ALU_SEQ_ACC_EN: accumulator (last result) may replace operand A per request.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [2:0]           req_command,
   input  logic [WIDTH-1:0]     req_a,
   input  logic [WIDTH-1:0]     req_b,
`ifdef ALU_SEQ_ACC_EN
   input  logic                 req_use_acc,
`endif
   output logic [WIDTH-1:0]     alu_operandA,
   output logic [WIDTH-1:0]     alu_operandB,
   output logic [2:0]           alu_command,
   input  logic [WIDTH-1:0]     alu_result,
   input  logic                 alu_carryout,
   input  logic                 alu_zero,
   input  logic                 alu_overflow,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [WIDTH-1:0]     rsp_result,
   output logic [NUM_FLAGS-1:0] rsp_flags,
   output logic                 busy
);
   // A zero or negative window would never sample; clamp to one cycle.
   localparam int            SC       = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
   localparam int            CW       = $clog2(SC) + 1;
   localparam logic [CW-1:0] LOAD_VAL = CW'(SC - 1);

   seq_state_t       state;
   logic             cnt_load, cnt_done;
   logic [WIDTH-1:0] op_a;

`ifdef ALU_SEQ_ACC_EN
   logic [WIDTH-1:0] acc;
   assign op_a = req_use_acc ? acc : req_a;
`else
   assign op_a = req_a;
`endif

   assign cnt_load = (state == ST_IDLE) && req_valid;

   alu_settle_counter #(.CW(CW)) u_cnt (
      .clk        (clk),
      .reset      (reset),
      .load       (cnt_load),
      .load_value (LOAD_VAL),
      .dec        (state == ST_SETTLE),
      .done       (cnt_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         alu_operandA <= '0;
         alu_operandB <= '0;
         alu_command  <= '0;
         rsp_result   <= '0;
         rsp_flags    <= '0;
`ifdef ALU_SEQ_ACC_EN
         acc          <= '0;
`endif
      end else begin
         case (state)
            ST_IDLE: if (req_valid) begin
               alu_operandA <= op_a;
               alu_operandB <= req_b;
               alu_command  <= req_command;
               state        <= ST_SETTLE;
            end
            ST_SETTLE: if (cnt_done) begin
               rsp_result           <= alu_result;
               rsp_flags[FLAG_OVF]  <= alu_overflow;
               rsp_flags[FLAG_ZERO] <= alu_zero;
               rsp_flags[FLAG_COUT] <= alu_carryout;
`ifdef ALU_SEQ_ACC_EN
               acc                  <= alu_result;
`endif
               state                <= ST_RESP;
            end
            ST_RESP: if (rsp_ready) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Handshake outputs come from state alone, never from inputs.
   assign req_ready = (state == ST_IDLE);
   assign rsp_valid = (state == ST_RESP);
   assign busy      = (state != ST_IDLE);
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 32-bit ALU attached.
module tb_alu_op_sequencer;
   localparam int SETTLE = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready;
   logic [2:0]  req_command;
   logic [31:0] req_a, req_b;
`ifdef ALU_SEQ_ACC_EN
   logic        req_use_acc;
`endif
   logic [31:0] alu_operandA, alu_operandB, alu_result;
   logic [2:0]  alu_command;
   logic        alu_carryout, alu_zero, alu_overflow;
   logic        rsp_valid, rsp_ready, busy;
   logic [31:0] rsp_result;
   logic [2:0]  rsp_flags;

   int n_chk = 0, n_fail = 0, cyc = 0, t_acc = 0, hs_cnt = 0;
   logic prev_valid = 1'b0;
   logic [34:0] exp_q[$];

   alu_op_sequencer #(.WIDTH(32), .SETTLE_CYCLES(SETTLE)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_command(req_command),
      .req_a(req_a), .req_b(req_b),
`ifdef ALU_SEQ_ACC_EN
      .req_use_acc(req_use_acc),
`endif
      .alu_operandA(alu_operandA), .alu_operandB(alu_operandB), .alu_command(alu_command),
      .alu_result(alu_result), .alu_carryout(alu_carryout), .alu_zero(alu_zero),
      .alu_overflow(alu_overflow),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_flags(rsp_flags), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Returns {overflow, zero, carryout, result}.
   function automatic logic [34:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic co, ov;
      s = '0; r = '0; co = 1'b0; ov = 1'b0;
      case (c)
         3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; co = s[32];
                     ov = (a[31] == b[31]) && (r[31] != a[31]); end
         3'd1: begin s = {1'b0, a} + {1'b0, ~b} + 33'd1; r = s[31:0]; co = s[32];
                     ov = (a[31] != b[31]) && (r[31] != a[31]); end
         3'd2: r = a ^ b;
         3'd3: r = {31'd0, $signed(a) < $signed(b)};
         3'd4: r = a & b;
         3'd5: r = ~(a & b);
         3'd6: r = ~(a | b);
         default: r = a | b;
      endcase
      return {ov, (r == 32'd0), co, r};
   endfunction

   assign {alu_overflow, alu_zero, alu_carryout, alu_result} = alu_ref(alu_command, alu_operandA, alu_operandB);

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Response monitor: pop on handshake, and time the first response cycle.
   always @(negedge clk) begin
      if (!reset) begin
         if (rsp_valid && !prev_valid) chk("latency", 64'(cyc - t_acc), SETTLE);
         if (rsp_valid && rsp_ready) begin
            hs_cnt++;
            if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
            else begin
               logic [34:0] e;
               e = exp_q.pop_front();
               chk("rsp_result", rsp_result, e[31:0]);
               chk("rsp_flags", rsp_flags, e[34:32]);
            end
         end
      end
      prev_valid = rsp_valid;
   end

   task automatic issue(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic use_acc, input logic [31:0] exp_opa, input logic push,
                        input logic [34:0] exp);
      int n;
      @(negedge clk);
      req_command = cmd; req_a = a; req_b = b; req_valid = 1'b1;
`ifdef ALU_SEQ_ACC_EN
      req_use_acc = use_acc;
`else
      if (use_acc) chk("acc_not_built", 1, 0);
`endif
      n = 0;
      while (!req_ready && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) chk("req_timeout", 0, 1);
      @(posedge clk); #1;
      t_acc = cyc;
      req_valid = 1'b0;
      if (push) exp_q.push_back(exp);
      chk("alu_operandA", alu_operandA, exp_opa);
      chk("alu_operandB", alu_operandB, b);
      chk("alu_command", alu_command, cmd);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!(req_ready && !rsp_valid) && n < 50) begin @(negedge clk); n++; end
      if (!req_ready) chk("idle_timeout", 0, 1);
   endtask

   task automatic run_op(input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b,
                         input logic [34:0] exp);
      issue(cmd, a, b, 1'b0, a, 1'b1, exp);
      wait_idle();
   endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_command = 3'd0; req_a = '0; req_b = '0;
      rsp_ready = 1'b1;
`ifdef ALU_SEQ_ACC_EN
      req_use_acc = 1'b0;
`endif
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", req_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_alu_a", alu_operandA, 0);
      chk("rst_alu_b", alu_operandB, 0);
      chk("rst_alu_cmd", alu_command, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_flags", rsp_flags, 0);

      // Directed cases with hand-derived results: {ovf,zero,cout,result}
      run_op(3'd0, 32'd5, 32'd7, {3'b000, 32'd12});
      run_op(3'd1, 32'd5, 32'd5, {3'b011, 32'd0});
      run_op(3'd0, 32'h7FFF_FFFF, 32'd1, {3'b100, 32'h8000_0000});

      // Backpressure: response must sit still while rsp_ready is low.
      rsp_ready = 1'b0;
      issue(3'd2, 32'h1234, 32'h1234, 1'b0, 32'h1234, 1'b1, {3'b010, 32'd0});
      begin
         int n;
         n = 0;
         while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
         chk("hold_seen_valid", rsp_valid, 1);
      end
      for (int i = 0; i < 10; i++) begin
         chk("hold_result", rsp_result, 32'd0);
         chk("hold_flags", rsp_flags, 3'b010);
         chk("hold_req_ready", req_ready, 0);
         chk("hold_busy", busy, 1);
         @(negedge clk);
      end
      begin
         int hs0;
         hs0 = hs_cnt;
         @(posedge clk); #1 rsp_ready = 1'b1;
         wait_idle();
         repeat (2) @(negedge clk);
         chk("hold_one_handshake", 64'(hs_cnt - hs0), 1);
         chk("hold_back_idle", req_ready, 1);
      end

      // Reset two cycles into SETTLE drops the operation.
      issue(3'd4, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 32'hFFFF_0000, 1'b0, '0);
      @(posedge clk); @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("mid_rst_req_ready", req_ready, 1);
      chk("mid_rst_rsp_valid", rsp_valid, 0);
      chk("mid_rst_alu_a", alu_operandA, 0);
      chk("mid_rst_alu_b", alu_operandB, 0);
      chk("mid_rst_alu_cmd", alu_command, 0);
      for (int i = 0; i < 8; i++) begin
         chk("mid_rst_no_rsp", rsp_valid, 0);
         @(negedge clk);
      end

      // Random mix against the reference ALU.
      for (int i = 0; i < 6; i++) begin
         logic [2:0]  c;
         logic [31:0] a, b;
         c = 3'($urandom_range(0, 7));
         a = $urandom; b = $urandom;
         if (i == 0) b = a;
         run_op(c, a, b, alu_ref(c, a, b));
      end

`ifdef ALU_SEQ_ACC_EN
      run_op(3'd0, 32'd3, 32'd4, {3'b000, 32'd7});
      issue(3'd0, 32'd99, 32'd10, 1'b1, 32'd7, 1'b1, {3'b000, 32'd17});
      wait_idle();
`endif

      repeat (3) @(negedge clk);
      chk("sb_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command-issuing front end for the 32-bit gate-level ALU. Accepts one operation at a time over a valid/ready request channel and drives operands and command into the ALU. It holds those inputs stable for a programmable settle window to cover the ALU's gate propagation delay, then captures the result and flags. The captured values are returned on a valid/ready response channel. It sits between a controller or testbench and the ALU, and is the initiator for the ALU's command interface.

## Interface
Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- SETTLE_CYCLES, 4, clock cycles that ALU inputs are held before sampling; values below 1 are treated as 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_command  in  3  ALU opcode.
- req_a  in  WIDTH  operand A.
- req_b  in  WIDTH  operand B.
- req_use_acc  in  1  substitute accumulator for operand A (present only with ALU_SEQ_ACC_EN).
- alu_operandA  out  WIDTH  registered drive to ALU operandA.
- alu_operandB  out  WIDTH  registered drive to ALU operandB.
- alu_command  out  3  registered drive to ALU command.
- alu_result  in  WIDTH  ALU result.
- alu_carryout, alu_zero, alu_overflow  in  1 each  ALU flags.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_result  out  WIDTH  captured result.
- rsp_flags  out  3  captured {overflow, zero, carryout}.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SETTLE, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, register the command and operands onto the alu_* outputs and load the settle counter with SETTLE_CYCLES-1. Go to SETTLE.
- SETTLE: req_ready=0. The alu_* outputs hold their values. The counter decrements each cycle.
  - When the counter is 0, capture alu_result and the flags into the rsp_* registers.
  - Then go to RESP.
- RESP: rsp_valid=1. rsp_result and rsp_flags stay stable until rsp_valid&&rsp_ready.
  - On that handshake, go to IDLE.
  - alu_* outputs keep their last values; they are not cleared.
- Only one operation is outstanding at a time. There is no request queueing.
- Requests arriving in SETTLE or RESP are not accepted. The requester must hold them until req_ready.
- Flags are passed through exactly as captured; the sequencer does no arithmetic.
- Settle counter width: $clog2(SETTLE_CYCLES)+1.

## Timing
- Reset values: state IDLE, req_ready=1 (the cycle after reset deasserts), rsp_valid=0, busy=0, all alu_* outputs 0, rsp_result 0, rsp_flags 0, accumulator 0.
- Accept at edge E0:
  - alu_* outputs show the new values after E0.
  - Capture happens at edge E0+SETTLE_CYCLES.
  - rsp_valid=1 after that edge.
- Latency from accept edge to rsp_valid: SETTLE_CYCLES cycles.
- Earliest response handshake: edge E0+SETTLE_CYCLES+1. req_ready=1 after that edge.
- Back-to-back period: SETTLE_CYCLES+2 cycles.
- req_ready and rsp_valid are decoded from state registers only. They do not depend combinationally on any input.
- Reset during SETTLE or RESP:
  - The in-flight operation is dropped and no response is produced.
  - rsp_valid=0 and req_ready=1 after the first non-reset edge.
- Reset takes priority over any handshake on the same edge.

## Configuration
- ALU_SEQ_ACC_EN defined:
  - Adds the req_use_acc port and a WIDTH-bit accumulator.
  - The accumulator loads rsp_result at every capture.
  - On accept with req_use_acc=1, alu_operandA takes the accumulator value instead of req_a.
- ALU_SEQ_ACC_EN undefined: no port and no accumulator; alu_operandA always takes req_a.

## Structure
- Shared package alu_pkg:
  - Opcode constants: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7.
  - Flag bit indices: OVF=2, ZERO=1, COUT=0.
  - State encoding constants.
- Sub-module alu_settle_counter: loadable down-counter with a done output. All other logic is inline.

## Test plan
The bench connects the real 32-bit ALU with SETTLE_CYCLES=4.
- ADD 5+7, rsp_ready=1 → rsp_result=12, rsp_flags=000, rsp_valid 4 cycles after accept.
- SUB 5-5 → rsp_result=0, zero=1, carryout=1, overflow=0.
- ADD 0x7FFFFFFF+1 → rsp_result=0x80000000, overflow=1, carryout=0.
- Hold rsp_ready=0 for 10 cycles after rsp_valid → rsp_result and rsp_flags stable, req_ready=0 throughout; one handshake, then IDLE.
- Assert reset 2 cycles into SETTLE → no rsp_valid; after reset, req_ready=1 and alu_* outputs are 0.
- With ALU_SEQ_ACC_EN: ADD 3+4, then ADD with req_use_acc=1 and req_b=10 → second rsp_result=17.
